draw_sprite: RTL and testbench
==============================

# draw_sprite

Parametrised sprite renderer and successor to the fixed-size single-frame sprite drawer in the game pipeline. It sits between `draw_menu` and the VGA outputs. It overlays a `SPR_W`×`SPR_H` sprite, taken from a multi-frame image ROM, onto the incoming VGA stream. Added behaviour:
- colour-key transparency;
- optional horizontal mirroring;
- frame-based animation;
- position latched once per frame, so there is no tearing.

## Interface
Parameters:
- `SPR_W`, default 64: sprite width in pixels.
- `SPR_H`, default 64: sprite height in pixels.
- `FRAMES`, default 4: number of animation frames stored consecutively in the ROM (≥1).
- `FRAME_TICKS`, default 8: video frames per animation step (≥1).
- `KEY_COLOR`, default 12'hF0F: ROM colour treated as transparent.
- `ADDR_W`, default `$clog2(SPR_W*SPR_H*FRAMES)`: ROM address width.

Ports:
- `clk` in, 1: pixel clock (40 MHz). Single clock domain.
- `rst` in, 1: synchronous, active-high reset.
- `xpos` in, 12: sprite left edge, screen pixels.
- `ypos` in, 12: sprite top edge, screen pixels.
- `mirror` in, 1: 1 = draw horizontally flipped (facing left).
- `anim_en` in, 1: 1 = animation advances.
- `pixel_addr` out, `ADDR_W`: registered ROM address.
- `rgb_pixel` in, 12: ROM data, valid one clk after `pixel_addr`.
- `in` `vga_if` input modport: upstream timing and rgb.
- `out` `vga_if` output modport: delayed timing and composited rgb.

## Operation
- **Position latch.** `x_l`, `y_l` and `mir_l` load `xpos`, `ypos` and `mirror` on the vblank rising edge, i.e. the first clk with `in.vblnk`=1 following a clk with `in.vblnk`=0. They hold for the rest of the frame.
- **Animation.**
  - On each vblank rising edge with `anim_en`=1, `tick` increments.
  - When `tick`=`FRAME_TICKS`-1, `tick` goes to 0 and `frame` increments.
  - `frame`=`FRAMES`-1 wraps to 0.
  - `anim_en`=0 clears `tick` and holds `frame`.
  - `FRAMES`=1: `frame` is fixed at 0.
- **Hit test (stage 0).** `hit` = (`in.hcount` ≥ `x_l`) && (`in.hcount` < `x_l`+`SPR_W`) && (`in.vcount` ≥ `y_l`) && (`in.vcount` < `y_l`+`SPR_H`).
  - Sums are computed 13 bits wide, with no wrap.
  - A sprite partially off the right or bottom edge is clipped.
- **Address.**
  - `col` = `in.hcount`-`x_l`; `row` = `in.vcount`-`y_l`.
  - `col'` = `mir_l` ? `SPR_W`-1-`col` : `col`.
  - `pixel_addr` = `frame`·`SPR_W`·`SPR_H` + `row`·`SPR_W` + `col'`, truncated to `ADDR_W`.
  - When `hit`=0, `pixel_addr` is 0.
- **Composite (stage 2).** `out.rgb` = (`hit_d2` && `rgb_pixel`≠`KEY_COLOR`) ? `rgb_pixel` : `rgb_d2`.
  - `rgb_d2` is the background after 2 clk of delay.
  - During blanking (`hblnk_d2` or `vblnk_d2`), `out.rgb` is 12'h000.
- **Reset.**
  - `pixel_addr`=0, all `out` fields=0.
  - `x_l`=`y_l`=0, `mir_l`=0, `frame`=0, `tick`=0, delay-pipe contents 0.
  - Reset mid-line takes effect on the next clk; output resumes with the correct alignment after 3 clk.

## Timing
- **Latency.** `out.hcount`, `vcount`, `hsync`, `vsync`, `hblnk` and `vblnk` equal `in.*` delayed by exactly 3 clk. `out.rgb` is aligned with them.
  - Edge 1: `pixel_addr` registered.
  - Edge 2: ROM data valid, `hit_d2`/`rgb_d2` aligned.
  - Edge 3: `out` registered.
- **Throughput.** One pixel per clk, no stalls, no handshake.
- **Frame boundaries.** Latched position and frame change only at the vblank edge. Changes to `xpos`, `ypos` or `mirror` mid-frame have no visible effect until the next frame.
- **Simultaneous events.** `rst` overrides the vblank edge. A vblank edge coinciding with `anim_en` falling uses the `anim_en` value sampled at that edge.

## Configuration
- **`SPRITE_MIRROR_EN` defined:** mirroring works as described above.
- **`SPRITE_MIRROR_EN` undefined:**
  - The `mirror` port remains but is ignored; `mir_l` is tied to 0.
  - `col'` = `col`, and the subtractor is removed.

## Structure
- The shared package `game_pkg` holds:
  - `SCREEN_W`=800 and `SCREEN_H`=600;
  - the 12-bit `pos_t` and `rgb_t` typedefs;
  - the default `KEY_COLOR`.
- One sub-module, `delay`, is a parametrised width/depth register pipe. It is used for the timing bus (depth 3), for `hit` and for rgb (depth 2).
- The image ROM stays external and is instantiated by the top.

## Test plan
1. **Basic draw.** `SPR_W`=`SPR_H`=64; `xpos`=100, `ypos`=50; ROM pixel(0,0)=12'h123.
   - `out.rgb`=12'h123 exactly 3 clk after `in.hcount`=100, `vcount`=50.
   - At `hcount`=99 or 164, `out.rgb` equals the background.
2. **Transparency.** The ROM word equals 12'hF0F inside the sprite.
   - `out.rgb` = background 12'hABC for that pixel.
3. **Mirror.** `mirror`=1 latched; `in.hcount`=100, `vcount`=50.
   - `pixel_addr`=63 one clk later.
   - With `SPRITE_MIRROR_EN` undefined, `pixel_addr`=0.
4. **Animation.** `FRAMES`=4, `FRAME_TICKS`=2, `anim_en`=1 for 8 vblank edges.
   - `frame` sequence 0,0,1,1,2,2,3,3 → 0.
   - After `anim_en`=0, `frame` holds and `tick`=0.
5. **Latch and clipping.** `xpos` changes 100→300 mid-frame: the current frame still draws at 100 and the next frame draws at 300. `xpos`=780: only columns 780–799 are drawn.
6. **Reset mid-frame.** `rst` asserted for 1 clk.
   - All outputs are 0 the next clk; `frame`=0.
   - The 3-clk-delayed timing is re-established.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-pipeline types: screen geometry, pixel/position types and the VGA timing payload.
package game_pkg;

  localparam int unsigned SCREEN_W = 800;
  localparam int unsigned SCREEN_H = 600;

  typedef logic [11:0] pos_t;
  typedef logic [11:0] rgb_t;

  localparam rgb_t DEFAULT_KEY_COLOR = 12'hF0F;

  // VGA timing bundle carried through the sprite delay pipe
  typedef struct packed {
    pos_t hcount;
    pos_t vcount;
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_timing_t;

  localparam int unsigned TIMING_W = $bits(vga_timing_t);

endpackage

// File: rtl/vga_if.sv
// VGA stream bundle: timing counters, sync/blank strobes and pixel colour.
interface vga_if;
  import game_pkg::*;

  pos_t hcount;
  pos_t vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  rgb_t rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/delay.sv
// Parametrised WIDTH x DEPTH register pipe with synchronous clear.
module delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/draw_sprite.sv
// Animated, colour-keyed sprite overlay on the VGA stream, 3 clk latency.
// Horizontal mirroring is built only when SPRITE_MIRROR_EN is defined.
module draw_sprite
  import game_pkg::*;
#(
  parameter int unsigned SPR_W       = 64,
  parameter int unsigned SPR_H       = 64,
  parameter int unsigned FRAMES      = 4,
  parameter int unsigned FRAME_TICKS = 8,
  parameter rgb_t        KEY_COLOR   = DEFAULT_KEY_COLOR,
  parameter int unsigned ADDR_W      = $clog2(SPR_W*SPR_H*FRAMES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              mirror,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [11:0]       rgb_pixel,
  vga_if.in                 in,
  vga_if.out                out
);

  localparam int unsigned FRAME_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned TICK_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned FRAME_PIX = SPR_W * SPR_H;

  logic               vblnk_q;
  logic               vb_rise;
  pos_t               x_l;
  pos_t               y_l;
  logic               mir_l;
  logic [FRAME_W-1:0] frame;
  logic [TICK_W-1:0]  tick;

  assign vb_rise = in.vblnk & ~vblnk_q;

  // Position is captured once per frame so a moving sprite never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      x_l     <= '0;
      y_l     <= '0;
    end else begin
      vblnk_q <= in.vblnk;
      if (vb_rise) begin
        x_l <= xpos;
        y_l <= ypos;
      end
    end
  end

`ifdef SPRITE_MIRROR_EN
  always_ff @(posedge clk) begin
    if (rst)          mir_l <= 1'b0;
    else if (vb_rise) mir_l <= mirror;
  end
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
  assign mir_l         = 1'b0;
`endif

  // Animation: tick counts vblank edges, frame steps every FRAME_TICKS of them
  always_ff @(posedge clk) begin
    if (rst) begin
      frame <= '0;
      tick  <= '0;
    end else if (!anim_en) begin
      tick <= '0;
    end else if (vb_rise) begin
      if (tick == TICK_W'(FRAME_TICKS - 1)) begin
        tick <= '0;
        if (FRAMES > 1 && frame != FRAME_W'(FRAMES - 1)) frame <= frame + FRAME_W'(1);
        else                                             frame <= '0;
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end

  // Stage 0: hit test in 13 bits so edge positions never wrap
  logic [12:0]       h13, v13, x13, y13;
  logic              hit;
  pos_t              col, row, col_m;
  logic [ADDR_W-1:0] addr;

  assign h13 = {1'b0, in.hcount};
  assign v13 = {1'b0, in.vcount};
  assign x13 = {1'b0, x_l};
  assign y13 = {1'b0, y_l};

  assign hit = (h13 >= x13) && (h13 < x13 + 13'(SPR_W)) &&
               (v13 >= y13) && (v13 < y13 + 13'(SPR_H));

  assign col = in.hcount - x_l;
  assign row = in.vcount - y_l;

`ifdef SPRITE_MIRROR_EN
  assign col_m = mir_l ? (12'(SPR_W - 1) - col) : col;
`else
  assign col_m = col;
`endif

  assign addr = ADDR_W'(32'(frame) * FRAME_PIX + 32'(row) * SPR_W + 32'(col_m));

  always_ff @(posedge clk) begin
    if (rst)      pixel_addr <= '0;
    else if (hit) pixel_addr <= addr;
    else          pixel_addr <= '0;
  end

  // Delay pipes: timing to the output edge, hit/blank and background to the ROM data edge
  vga_timing_t t_in, t_d3;
  logic        hit_d2, hblnk_d2, vblnk_d2;
  rgb_t        rgb_d2;

  assign t_in = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync,
                  vsync: in.vsync, hblnk: in.hblnk, vblnk: in.vblnk};

  delay #(.WIDTH(TIMING_W), .DEPTH(3)) u_timing_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (t_in),
    .dout (t_d3)
  );

  delay #(.WIDTH(3), .DEPTH(2)) u_hit_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({hit, in.hblnk, in.vblnk}),
    .dout ({hit_d2, hblnk_d2, vblnk_d2})
  );

  delay #(.WIDTH(12), .DEPTH(2)) u_rgb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (in.rgb),
    .dout (rgb_d2)
  );

  assign out.hcount = t_d3.hcount;
  assign out.vcount = t_d3.vcount;
  assign out.hsync  = t_d3.hsync;
  assign out.vsync  = t_d3.vsync;
  assign out.hblnk  = t_d3.hblnk;
  assign out.vblnk  = t_d3.vblnk;

  // Stage 2 composite: key colour shows the background, blanking forces black
  always_ff @(posedge clk) begin
    if (rst)                              out.rgb <= '0;
    else if (hblnk_d2 || vblnk_d2)        out.rgb <= '0;
    else if (hit_d2 && rgb_pixel != KEY_COLOR) out.rgb <= rgb_pixel;
    else                                  out.rgb <= rgb_d2;
  end

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite: streamed vector tables plus latch, animation and reset sequences.
module tb_draw_sprite;

  logic        clk;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        mirror, anim_en;
  logic [13:0] pixel_addr;
  logic [11:0] rgb_pixel;

  vga_if vin();
  vga_if vout();

  draw_sprite #(
    .SPR_W(64), .SPR_H(64), .FRAMES(4), .FRAME_TICKS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .mirror     (mirror),
    .anim_en    (anim_en),
    .pixel_addr (pixel_addr),
    .rgb_pixel  (rgb_pixel),
    .in         (vin),
    .out        (vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image ROM model: one registered read, a few marked words
  function automatic logic [11:0] rom_model(input logic [13:0] a);
    if (a == 14'd0) return 12'h123;
    if (a == 14'd5) return 12'hF0F;
    return 12'(a) + 12'h200;
  endfunction

  always_ff @(posedge clk) rgb_pixel <= rom_model(pixel_addr);

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic        hb;
    logic [11:0] bg;
    logic [13:0] exp_addr;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vq[$];
  int   pass_cnt = 0;
  int   total    = 0;

  localparam bit MIR = `ifdef SPRITE_MIRROR_EN 1'b1 `else 1'b0 `endif;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic hb,
                       input logic vb, input logic [11:0] bg);
    vin.hcount = h;
    vin.vcount = v;
    vin.hsync  = h[0];
    vin.vsync  = v[0];
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = bg;
  endtask

  task automatic push(input logic [11:0] h, input logic [11:0] v, input logic hb,
                      input logic [11:0] bg, input logic [13:0] ea, input logic [11:0] er);
    vec_t e;
    e.h = h; e.v = v; e.hb = hb; e.bg = bg; e.exp_addr = ea; e.exp_rgb = er;
    vq.push_back(e);
  endtask

  // One pixel per clk; pixel_addr checked 1 clk later, out.* 3 clk later
  task automatic run_vecs(input string tag);
    int n;
    n = vq.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drive(vq[i].h, vq[i].v, vq[i].hb, 1'b0, vq[i].bg);
      else       drive(12'd0, 12'd0, 1'b1, 1'b0, 12'h000);
      step();
      if (i < n) check($sformatf("%s[%0d].addr", tag, i), 32'(pixel_addr), 32'(vq[i].exp_addr));
      if (i >= 2) begin
        check($sformatf("%s[%0d].rgb", tag, i-2), 32'(vout.rgb), 32'(vq[i-2].exp_rgb));
        check($sformatf("%s[%0d].hcount", tag, i-2), 32'(vout.hcount), 32'(vq[i-2].h));
      end
    end
    vq.delete();
  endtask

  task automatic vb_edge();
    drive(12'd0, 12'd0, 1'b1, 1'b0, 12'h000); step();
    drive(12'd0, 12'd0, 1'b1, 1'b1, 12'h000); step();
    drive(12'd0, 12'd0, 1'b1, 1'b0, 12'h000); step();
  endtask

  initial begin
    rst = 1'b1; xpos = 12'd0; ypos = 12'd0; mirror = 1'b0; anim_en = 1'b0;
    drive(12'd5, 12'd5, 1'b0, 1'b0, 12'hFFF);
    step(); step();
    check("reset.addr", 32'(pixel_addr), 32'd0);
    check("reset.rgb", 32'(vout.rgb), 32'd0);
    check("reset.hcount", 32'(vout.hcount), 32'd0);
    check("reset.vsync", 32'(vout.vsync), 32'd0);
    rst = 1'b0;

    // Basic draw, edges, transparency, blanking
    xpos = 12'd100; ypos = 12'd50;
    vb_edge();
    push(12'd100, 12'd50,  1'b0, 12'h0AA, 14'd0,    12'h123);
    push(12'd99,  12'd50,  1'b0, 12'hABC, 14'd0,    12'hABC);
    push(12'd164, 12'd50,  1'b0, 12'h111, 14'd0,    12'h111);
    push(12'd163, 12'd50,  1'b0, 12'h222, 14'd63,   12'h23F);
    push(12'd105, 12'd50,  1'b0, 12'hABC, 14'd5,    12'hABC);
    push(12'd101, 12'd51,  1'b0, 12'h333, 14'd65,   12'h241);
    push(12'd100, 12'd113, 1'b0, 12'h444, 14'd4032, 12'h1C0);
    push(12'd100, 12'd114, 1'b0, 12'h555, 14'd0,    12'h555);
    push(12'd120, 12'd60,  1'b1, 12'h666, 14'd660,  12'h000);
    push(12'd100, 12'd49,  1'b0, 12'h777, 14'd0,    12'h777);
    run_vecs("basic");

    // Mirror
    mirror = 1'b1;
    vb_edge();
    push(12'd100, 12'd50, 1'b0, 12'h040, MIR ? 14'd63 : 14'd0, MIR ? 12'h23F : 12'h123);
    push(12'd163, 12'd50, 1'b0, 12'h041, MIR ? 14'd0 : 14'd63, MIR ? 12'h123 : 12'h23F);
    run_vecs("mirror");
    mirror = 1'b0;

    // Mid-frame position change waits for the next vblank edge
    vb_edge();
    xpos = 12'd300;
    push(12'd101, 12'd50, 1'b0, 12'h010, 14'd1, 12'h201);
    push(12'd301, 12'd50, 1'b0, 12'h020, 14'd0, 12'h020);
    run_vecs("latch_old");
    vb_edge();
    push(12'd301, 12'd50, 1'b0, 12'h021, 14'd1, 12'h201);
    push(12'd101, 12'd50, 1'b0, 12'h011, 14'd0, 12'h011);
    run_vecs("latch_new");

    // Right-edge clipping
    xpos = 12'd780;
    vb_edge();
    push(12'd799, 12'd50, 1'b0, 12'h030, 14'd19, 12'h213);
    push(12'd779, 12'd50, 1'b0, 12'h031, 14'd0,  12'h031);
    push(12'd780, 12'd50, 1'b0, 12'h032, 14'd0,  12'h123);
    run_vecs("clip");

    // Animation: two vblank edges per frame step, wrap after four frames
    xpos = 12'd100;
    vb_edge();
    anim_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(12'd100, 12'd50, 1'b0, 12'h050, 14'((k / 2) * 4096), rom_model(14'((k / 2) * 4096)));
      run_vecs($sformatf("anim%0d", k));
      vb_edge();
    end
    push(12'd100, 12'd50, 1'b0, 12'h050, 14'd0, 12'h123);
    run_vecs("anim_wrap");
    vb_edge(); vb_edge(); vb_edge();
    anim_en = 1'b0;
    step();
    vb_edge();
    push(12'd100, 12'd50, 1'b0, 12'h050, 14'd4096, 12'h200);
    run_vecs("anim_hold");
    anim_en = 1'b1;
    vb_edge();
    push(12'd100, 12'd50, 1'b0, 12'h050, 14'd4096, 12'h200);
    run_vecs("anim_tick_cleared");
    vb_edge();
    push(12'd100, 12'd50, 1'b0, 12'h050, 14'd8192, 12'h200);
    run_vecs("anim_resume");

    // Reset mid-frame with a full pipeline
    drive(12'd100, 12'd50, 1'b0, 1'b0, 12'h0F0); step(); step();
    rst = 1'b1;
    step();
    check("midrst.addr", 32'(pixel_addr), 32'd0);
    check("midrst.rgb", 32'(vout.rgb), 32'd0);
    check("midrst.hcount", 32'(vout.hcount), 32'd0);
    check("midrst.vcount", 32'(vout.vcount), 32'd0);
    rst = 1'b0;
    push(12'd10, 12'd20, 1'b0, 12'h0F1, 14'd1290, 12'h70A);
    push(12'd11, 12'd20, 1'b0, 12'h0F2, 14'd1291, 12'h70B);
    run_vecs("after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
